// File: rtl/fp32_dot_sequencer.sv
// -----------------------------------------------------------------------------
// fp32_dot_sequencer
//
// Computes an FP32 dot product of programmable length. A start command loads
// the element count and clears the accumulator. Each operand pair accepted on
// the op stream is multiplied and added into a registered accumulator through
// one combinational FP32 multiplier + adder (acc + alpha*bravo, with a separate
// rounding step after each operation). The final sum is offered on a
// valid/ready result port.
//
// Arithmetic: IEEE-754 binary32, round-to-nearest-even. NaN and Inf propagate
// (invalid operations return the canonical quiet NaN 0x7FC00000). Denormal
// inputs are read as zero, and results that would be denormal flush to zero.
// No exception flags are produced.
//
// Ports:
//   clk, rst                       clock; synchronous active-high reset
//   start_valid/start_ready        start command handshake
//   start_len[LEN_WIDTH-1:0]       number of operand pairs (0 = empty sum)
//   op_valid/op_ready              operand pair handshake
//   op_alpha, op_bravo [31:0]      FP32 operands
//   res_valid/res_ready            result handshake
//   res_data [31:0]                FP32 dot-product result
//   busy                           high in any state other than IDLE
//
// Optional build macro FP32_DOT_SEQ_PIPE_EN:
//   Adds an operand stage register in front of the MAC and a one-cycle DRAIN
//   state. The result then appears 2 cycles after the last operand handshake
//   instead of 1. Throughput stays one pair per cycle.
// -----------------------------------------------------------------------------
module fp32_dot_sequencer #(
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [LEN_WIDTH-1:0] start_len,
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [31:0]          op_alpha,
  input  logic [31:0]          op_bravo,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic                 busy
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
`ifdef FP32_DOT_SEQ_PIPE_EN
    S_DRAIN,
`endif
    S_DONE
  } state_t;

  // Leading-zero count of a 27-bit value (0 when the value is zero).
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn;
    logic        [47:0] prod;
    logic        [23:0] mant;
    logic        [24:0] rnd;
    logic               g, st;
    logic signed [9:0]  ex;
    logic        [31:0] r;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    sgn    = a[31] ^ b[31];
    prod   = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    ex     = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
    // The 24x24 product lies in [1,4); normalise to [1,2) keeping guard/sticky.
    if (prod[47]) begin
      mant = prod[47:24];
      g    = prod[23];
      st   = |prod[22:0];
      ex   = ex + 10'sd1;
    end else begin
      mant = prod[46:23];
      g    = prod[22];
      st   = |prod[21:0];
    end
    rnd = {1'b0, mant} + {24'd0, g & (st | mant[0])};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      ex  = ex + 10'sd1;
    end
    if (ex >= 10'sd255)   r = {sgn, 8'hFF, 23'd0};
    else if (ex <= 10'sd0) r = {sgn, 31'd0};
    else                  r = {sgn, ex[7:0], rnd[22:0]};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) r = QNAN;
    else if (a_inf || b_inf)                                      r = {sgn, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                                    r = {sgn, 31'd0};
    return r;
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic        [31:0] big, sml, r;
    logic        [7:0]  diff;
    logic        [26:0] bm, sm, sa, m;
    logic        [27:0] sum;
    logic        [24:0] rnd;
    logic        [4:0]  lz;
    logic               g, st;
    logic signed [9:0]  ex;
    a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (a[30:23] == 8'h00);
    b_zero = (b[30:23] == 8'h00);
    // Order by magnitude so the difference is never negative and the
    // result takes the sign of the larger operand.
    if (a[30:0] >= b[30:0]) begin
      big = a;
      sml = b;
    end else begin
      big = b;
      sml = a;
    end
    diff = big[30:23] - sml[30:23];
    // Mantissas carry 3 low bits (guard, round, sticky) for rounding.
    bm = {1'b1, big[22:0], 3'b000};
    sm = {1'b1, sml[22:0], 3'b000};
    if (diff >= 8'd27) begin
      sa = 27'd1;                      // entirely below the round bit: sticky only
    end else begin
      sa = sm >> diff;
      if ((sa << diff) != sm) sa[0] = 1'b1;
    end
    sum = (big[31] ^ sml[31]) ? ({1'b0, bm} - {1'b0, sa}) : ({1'b0, bm} + {1'b0, sa});
    ex  = $signed({2'b00, big[30:23]});
    lz  = 5'd0;
    if (sum[27]) begin
      m  = sum[27:1] | {26'd0, sum[0]};
      ex = ex + 10'sd1;
    end else begin
      lz = lzc27(sum[26:0]);
      m  = sum[26:0] << lz;
      ex = ex - $signed({5'd0, lz});
    end
    g   = m[2];
    st  = |m[1:0];
    rnd = {1'b0, m[26:3]} + {24'd0, g & (st | m[3])};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      ex  = ex + 10'sd1;
    end
    if (sum == 28'd0)      r = 32'h0000_0000;   // exact cancellation gives +0
    else if (ex >= 10'sd255) r = {big[31], 8'hFF, 23'd0};
    else if (ex <= 10'sd0)   r = {big[31], 31'd0};
    else                   r = {big[31], ex[7:0], rnd[22:0]};
    if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) r = QNAN;
    else if (a_inf)              r = a;
    else if (b_inf)              r = b;
    else if (a_zero && b_zero)   r = {a[31] & b[31], 31'd0};
    else if (a_zero)             r = b;
    else if (b_zero)             r = a;
    return r;
  endfunction

  state_t               state_q, state_d;
  logic [31:0]          acc_q, acc_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [31:0]          mac_out;

`ifdef FP32_DOT_SEQ_PIPE_EN
  logic [31:0] alpha_q, alpha_d, bravo_q, bravo_d;
  logic        stage_valid_q, stage_valid_d;
  assign mac_out = fp_add(acc_q, fp_mul(alpha_q, bravo_q));
`else
  assign mac_out = fp_add(acc_q, fp_mul(op_alpha, op_bravo));
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    acc_d       = acc_q;
    rem_d       = rem_q;
    start_ready = 1'b0;
    op_ready    = 1'b0;
    res_valid   = 1'b0;
`ifdef FP32_DOT_SEQ_PIPE_EN
    stage_valid_d = 1'b0;
    alpha_d       = alpha_q;
    bravo_d       = bravo_q;
    // A staged pair is folded in one cycle after its handshake.
    if (stage_valid_q) acc_d = mac_out;
`endif
    case (state_q)
      S_IDLE: begin
        start_ready = !rst;
        if (start_valid && !rst) begin
          acc_d   = 32'h0000_0000;
          rem_d   = start_len;
          state_d = (start_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        op_ready = 1'b1;
        if (op_valid) begin
          rem_d = rem_q - LEN_WIDTH'(1);
`ifdef FP32_DOT_SEQ_PIPE_EN
          stage_valid_d = 1'b1;
          alpha_d       = op_alpha;
          bravo_d       = op_bravo;
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DRAIN;
`else
          acc_d = mac_out;
          if (rem_q == LEN_WIDTH'(1)) state_d = S_DONE;
`endif
        end
      end
`ifdef FP32_DOT_SEQ_PIPE_EN
      S_DRAIN: begin
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign res_data = acc_q;
  assign busy     = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= 32'h0000_0000;
      rem_q   <= '0;
`ifdef FP32_DOT_SEQ_PIPE_EN
      stage_valid_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
`ifdef FP32_DOT_SEQ_PIPE_EN
      stage_valid_q <= stage_valid_d;
`endif
    end
  end

`ifdef FP32_DOT_SEQ_PIPE_EN
  // NOTE: the operand stage is pure datapath qualified by stage_valid_q, so
  // it is left without reset; only the valid bit needs a defined value.
  always_ff @(posedge clk) begin
    alpha_q <= alpha_d;
    bravo_q <= bravo_d;
  end
`endif

endmodule

// File: tb/tb_fp32_dot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fp32_dot_sequencer
//
// Directed bench for fp32_dot_sequencer. Inputs are driven and outputs are
// sampled on the falling clock edge, half a cycle away from the active edge.
// Expected values are hand-computed FP32 constants.
// -----------------------------------------------------------------------------
module tb_fp32_dot_sequencer;

`ifdef FP32_DOT_SEQ_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam logic [31:0] F_0_5 = 32'h3F00_0000;
  localparam logic [31:0] F_1   = 32'h3F80_0000;
  localparam logic [31:0] F_2   = 32'h4000_0000;
  localparam logic [31:0] F_3   = 32'h4040_0000;
  localparam logic [31:0] F_4   = 32'h4080_0000;
  localparam logic [31:0] F_5   = 32'h40A0_0000;
  localparam logic [31:0] F_11  = 32'h4130_0000;

  logic        clk;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  start_len;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_alpha;
  logic [31:0] op_bravo;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int lat;

  fp32_dot_sequencer #(.LEN_WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_len   (start_len),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_alpha    (op_alpha),
    .op_bravo    (op_bravo),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send_start(input logic [7:0] len);
    start_valid = 1'b1;
    start_len   = len;
    step();
    start_valid = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    op_alpha = a;
    op_bravo = b;
    step();
    op_valid = 1'b0;
  endtask

  // Called right after the last operand handshake; returns the number of
  // cycles until res_valid is seen (16 on timeout).
  task automatic wait_result(output int cycles);
    cycles = 1;
    while (!res_valid && cycles < 16) begin
      step();
      cycles++;
    end
  endtask

  task automatic test_reset();
    step();
    total++; if (start_ready !== 1'b0) begin bad++; $display("FAIL rst_start_ready got=%b exp=0", start_ready); end
    total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL rst_op_ready got=%b exp=0", op_ready); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got=%b exp=0", res_valid); end
    total++; if (res_data !== 32'h0) begin bad++; $display("FAIL rst_res_data got=%h exp=00000000", res_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    step();
    total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL idle_start_ready got=%b exp=1", start_ready); end
  endtask

  task automatic test_basic();
    send_start(8'd2);
    total++; if (op_ready !== 1'b1 || busy !== 1'b1 || start_ready !== 1'b0) begin
      bad++; $display("FAIL basic_run_flags got op_ready=%b busy=%b start_ready=%b exp 1 1 0", op_ready, busy, start_ready); end
    send_op(F_1, F_3);
    send_op(F_2, F_4);
    wait_result(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL basic_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (res_data !== F_11) begin bad++; $display("FAIL basic_data got=%h exp=%h", res_data, F_11); end
    total++; if (op_ready !== 1'b0 || start_ready !== 1'b0) begin
      bad++; $display("FAIL basic_done_ready got op_ready=%b start_ready=%b exp 0 0", op_ready, start_ready); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      bad++; $display("FAIL basic_back_idle got res_valid=%b busy=%b start_ready=%b exp 0 0 1", res_valid, busy, start_ready); end
  endtask

  task automatic test_len1();
    send_start(8'd1);
    send_op(F_2, F_0_5);
    wait_result(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL len1_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (res_data !== F_1) begin bad++; $display("FAIL len1_data got=%h exp=%h", res_data, F_1); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL len1_idle got busy=%b exp=0", busy); end
  endtask

  task automatic test_len0();
    op_valid = 1'b1;
    op_alpha = F_5;
    op_bravo = F_5;
    send_start(8'd0);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL len0_res_valid got=%b exp=1", res_valid); end
    total++; if (res_data !== 32'h0) begin bad++; $display("FAIL len0_data got=%h exp=00000000", res_data); end
    total++; if (op_ready !== 1'b0) begin bad++; $display("FAIL len0_op_ready got=%b exp=0", op_ready); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    op_valid  = 1'b0;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL len0_idle got res_valid=%b busy=%b exp 0 0", res_valid, busy); end
  endtask

  task automatic test_gapped_backpressure();
    send_start(8'd3);
    for (int i = 0; i < 5; i++) begin
      op_valid = (i % 2 == 0);
      op_alpha = F_1;
      op_bravo = F_1;
      step();
      if (i == 2) begin
        total++; if (op_ready !== 1'b1) begin bad++; $display("FAIL gap_mid_op_ready got=%b exp=1", op_ready); end
      end
    end
    op_valid = 1'b0;
    wait_result(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL gap_latency got=%0d exp=%0d", lat, LAT); end
    for (int i = 0; i < 5; i++) begin
      total++; if (res_valid !== 1'b1 || res_data !== F_3 || start_ready !== 1'b0) begin
        bad++; $display("FAIL gap_hold[%0d] got res_valid=%b data=%h start_ready=%b exp 1 %h 0", i, res_valid, res_data, start_ready, F_3); end
      step();
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0 || start_ready !== 1'b1) begin
      bad++; $display("FAIL gap_back_idle got res_valid=%b busy=%b start_ready=%b exp 0 0 1", res_valid, busy, start_ready); end
  endtask

  task automatic test_reset_mid_run();
    send_start(8'd4);
    send_op(F_3, F_3);
    send_op(F_3, F_3);
    rst = 1'b1;
    step();
    total++; if (start_ready !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_ready got start_ready=%b op_ready=%b res_valid=%b exp 0 0 0", start_ready, op_ready, res_valid); end
    total++; if (res_data !== 32'h0 || busy !== 1'b0) begin
      bad++; $display("FAIL midrst_state got data=%h busy=%b exp 00000000 0", res_data, busy); end
    rst = 1'b0;
    step();
    total++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++; $display("FAIL midrst_idle got start_ready=%b res_valid=%b exp 1 0", start_ready, res_valid); end
    send_start(8'd1);
    send_op(F_2, F_2);
    wait_result(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL midrst_latency got=%0d exp=%0d", lat, LAT); end
    total++; if (res_data !== F_4) begin bad++; $display("FAIL midrst_data got=%h exp=%h", res_data, F_4); end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  task automatic test_ignored_inputs();
    op_valid = 1'b1;
    op_alpha = F_5;
    op_bravo = F_5;
    step();
    step();
    total++; if (op_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL ign_idle got op_ready=%b busy=%b exp 0 0", op_ready, busy); end
    op_valid = 1'b0;
    send_start(8'd2);
    start_valid = 1'b1;
    start_len   = 8'd7;
    step();
    start_valid = 1'b0;
    total++; if (start_ready !== 1'b0 || op_ready !== 1'b1) begin
      bad++; $display("FAIL ign_start_in_run got start_ready=%b op_ready=%b exp 0 1", start_ready, op_ready); end
    send_op(F_1, F_3);
    send_op(F_2, F_4);
    wait_result(lat);
    total++; if (lat !== LAT) begin bad++; $display("FAIL ign_latency got=%0d exp=%0d", lat, LAT); end
    op_valid    = 1'b1;
    op_alpha    = F_5;
    op_bravo    = F_5;
    start_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (res_valid !== 1'b1 || res_data !== F_11 || op_ready !== 1'b0 || start_ready !== 1'b0) begin
        bad++; $display("FAIL ign_done[%0d] got res_valid=%b data=%h op_ready=%b start_ready=%b exp 1 %h 0 0", i, res_valid, res_data, op_ready, start_ready, F_11); end
    end
    op_valid    = 1'b0;
    start_valid = 1'b0;
    res_ready   = 1'b1;
    step();
    res_ready = 1'b0;
    step();
    total++; if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++; $display("FAIL ign_no_queued_start got busy=%b res_valid=%b exp 0 0", busy, res_valid); end
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b1;
    send_start(8'd1);
    send_op(F_2, F_2);
    wait_result(lat);
    total++; if (res_data !== F_4 || lat !== LAT) begin
      bad++; $display("FAIL b2b_first got data=%h lat=%0d exp %h %0d", res_data, lat, F_4, LAT); end
    step();
    total++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_idle got start_ready=%b res_valid=%b exp 1 0", start_ready, res_valid); end
    send_start(8'd1);
    send_op(F_1, F_3);
    wait_result(lat);
    total++; if (res_data !== F_3 || lat !== LAT) begin
      bad++; $display("FAIL b2b_second got data=%h lat=%0d exp %h %0d", res_data, lat, F_3, LAT); end
    step();
    res_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_end got busy=%b exp=0", busy); end
  endtask

  initial begin
    rst         = 1'b1;
    start_valid = 1'b0;
    start_len   = 8'd0;
    op_valid    = 1'b0;
    op_alpha    = 32'h0;
    op_bravo    = 32'h0;
    res_ready   = 1'b0;
    test_reset();
    test_basic();
    test_len1();
    test_len0();
    test_gapped_backpressure();
    test_reset_mid_run();
    test_ignored_inputs();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
